// File: rtl/lineto_queue.sv
// lineto_queue: queued Bresenham line stepper for the vector display path.
//
// Endpoints (x,y,z) are pushed into a DEPTH-entry FIFO. The stepper pops one
// endpoint at a time and walks x_out/y_out one LSB per step toward it. Diagonal
// steps are allowed. Each step waits step_div+1 clocks. z_out carries the
// intensity of the active segment and is 0 whenever no segment is active.
//
// Ports
//   clk        system clock, all logic on posedge
//   reset      synchronous, active-high
//   in_valid   endpoint offered
//   in_ready   FIFO not full; push happens on in_valid && in_ready
//   x_in/y_in  endpoint coordinates (unsigned)
//   z_in       segment intensity (0 = blanked move)
//   step_div   dwell per step, sampled when an endpoint is popped
//   x_out/y_out current beam position
//   z_out      current intensity, 0 when idle
//   seg_done   one-clock pulse when a segment completes
//   busy       stepper active, FIFO non-empty, or completion pulse pending
//   dbg_state  current FSM state (0 IDLE, 1 LOAD, 2 STEP)
//
// Handshake: an endpoint transfers on the rising edge where in_valid and
// in_ready are both high. in_ready depends only on registered state. in_valid
// may be asserted or dropped at any time.

module lineto_queue #(
    parameter int BITS    = 16,
    parameter int ZBITS   = 8,
    parameter int DEPTH   = 16,
    parameter int DIVBITS = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [BITS-1:0]    x_in,
    input  logic [BITS-1:0]    y_in,
    input  logic [ZBITS-1:0]   z_in,
    input  logic [DIVBITS-1:0] step_div,
    output logic [BITS-1:0]    x_out,
    output logic [BITS-1:0]    y_out,
    output logic [ZBITS-1:0]   z_out,
    output logic               seg_done,
    output logic               busy,
    output logic [1:0]         dbg_state
);

    localparam int AW = $clog2(DEPTH);
    localparam int EW = 2 * BITS + ZBITS;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_STEP = 2'd2
    } state_t;

    state_t               state_q;
    logic [EW-1:0]        mem_q [DEPTH];
    logic [AW-1:0]        wr_ptr_q, rd_ptr_q;
    logic [AW:0]          count_q;

    logic [BITS-1:0]      dst_x_q, dst_y_q;
    logic [ZBITS-1:0]     z_lat_q;
    logic [DIVBITS-1:0]   div_q, div_cnt_q;
    logic [BITS-1:0]      dx_q, dy_q;
    logic                 sx_q, sy_q;          // 1 = move toward larger coordinate
    logic signed [BITS+1:0] err_q;
    logic [BITS-1:0]      x_q, y_q;
    logic [ZBITS-1:0]     z_q;
    logic                 seg_done_q;

    logic                 push, pop, tick, land;
    logic [EW-1:0]        head;
    logic [BITS-1:0]      head_x, head_y;
    logic [ZBITS-1:0]     head_z;
    logic signed [BITS+2:0] e2, dx_w, dy_w;
    logic signed [BITS+1:0] dx_e, dy_e, err_d, load_err;
    logic                 step_x, step_y;
    logic [BITS-1:0]      nx_d, ny_d, load_dx, load_dy;

    assign in_ready  = (count_q != (AW+1)'(DEPTH));
    assign push      = in_valid && in_ready;
    assign head      = mem_q[rd_ptr_q];
    assign head_x    = head[EW-1 -: BITS];
    assign head_y    = head[EW-BITS-1 -: BITS];
    assign head_z    = head[ZBITS-1:0];

    // A step fires when the dwell counter reaches the latched divider. The
    // segment completes on the step that lands on the destination; a
    // zero-length segment computes no movement and so completes on its first
    // tick, after dwelling step_div+1 clocks.
    assign tick = (state_q == S_STEP) && (div_cnt_q == div_q);
    assign land = tick && (nx_d == dst_x_q) && (ny_d == dst_y_q);
    assign pop  = (count_q != '0) && ((state_q == S_IDLE) || land);

    always_comb begin
        load_dx  = (dst_x_q >= x_q) ? dst_x_q - x_q : x_q - dst_x_q;
        load_dy  = (dst_y_q >= y_q) ? dst_y_q - y_q : y_q - dst_y_q;
        load_err = $signed({2'b00, load_dx}) - $signed({2'b00, load_dy});

        // err spans [-dy, dx], so doubling it needs one extra bit.
        e2     = $signed({err_q, 1'b0});
        dx_w   = $signed({3'b000, dx_q});
        dy_w   = $signed({3'b000, dy_q});
        dx_e   = $signed({2'b00, dx_q});
        dy_e   = $signed({2'b00, dy_q});
        step_x = (e2 > -dy_w);
        step_y = (e2 < dx_w);

        err_d = err_q;
        nx_d  = x_q;
        ny_d  = y_q;
        if (step_x) begin
            err_d = err_d - dy_e;
            nx_d  = sx_q ? x_q + BITS'(1) : x_q - BITS'(1);
        end
        if (step_y) begin
            err_d = err_d + dx_e;
            ny_d  = sy_q ? y_q + BITS'(1) : y_q - BITS'(1);
        end
    end

    // FIFO storage is not reset; the pointers and count define its contents.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {x_in, y_in, z_in};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            dst_x_q    <= '0;
            dst_y_q    <= '0;
            z_lat_q    <= '0;
            div_q      <= '0;
            div_cnt_q  <= '0;
            dx_q       <= '0;
            dy_q       <= '0;
            sx_q       <= 1'b0;
            sy_q       <= 1'b0;
            err_q      <= '0;
            x_q        <= '0;
            y_q        <= '0;
            z_q        <= '0;
            seg_done_q <= 1'b0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            if (push && !pop)      count_q <= count_q + (AW+1)'(1);
            else if (pop && !push) count_q <= count_q - (AW+1)'(1);

            seg_done_q <= 1'b0;

            // Popping latches destination, intensity and divider together, so
            // a step_div change only affects segments popped afterwards.
            if (pop) begin
                dst_x_q <= head_x;
                dst_y_q <= head_y;
                z_lat_q <= head_z;
                div_q   <= step_div;
            end

            case (state_q)
                S_IDLE: begin
                    z_q <= '0;
                    if (pop) state_q <= S_LOAD;
                end
                S_LOAD: begin
                    dx_q      <= load_dx;
                    dy_q      <= load_dy;
                    sx_q      <= (dst_x_q >= x_q);
                    sy_q      <= (dst_y_q >= y_q);
                    err_q     <= load_err;
                    z_q       <= z_lat_q;
                    div_cnt_q <= '0;
                    state_q   <= S_STEP;
                end
                S_STEP: begin
                    if (tick) begin
                        div_cnt_q <= '0;
                        x_q       <= nx_d;
                        y_q       <= ny_d;
                        err_q     <= err_d;
                        if (land) begin
                            seg_done_q <= 1'b1;
                            // Back-to-back segments go straight to LOAD and
                            // keep the old intensity for that one clock.
                            if (pop) begin
                                state_q <= S_LOAD;
                            end else begin
                                state_q <= S_IDLE;
                                z_q     <= '0;
                            end
                        end
                    end else begin
                        div_cnt_q <= div_cnt_q + DIVBITS'(1);
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    z_q     <= '0;
                end
            endcase
        end
    end

    assign x_out     = x_q;
    assign y_out     = y_q;
    assign z_out     = z_q;
    assign seg_done  = seg_done_q;
    assign busy      = (state_q != S_IDLE) || (count_q != '0) || seg_done_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_lineto_queue.sv
// Bench for lineto_queue: directed endpoints, expected segment results queued
// at push time and checked by a monitor on every seg_done pulse.

module tb_lineto_queue;

  localparam int BITS    = 12;
  localparam int ZBITS   = 8;
  localparam int DEPTH   = 4;
  localparam int DIVBITS = 8;
  localparam int CW      = BITS + 1;
  localparam int W       = 2 * BITS + ZBITS + 2 * CW + DIVBITS;

  // clock / reset
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic               in_valid = 1'b0;
  logic               in_ready;
  logic [BITS-1:0]    x_in = '0;
  logic [BITS-1:0]    y_in = '0;
  logic [ZBITS-1:0]   z_in = '0;
  logic [DIVBITS-1:0] step_div = '0;
  logic [BITS-1:0]    x_out, y_out;
  logic [ZBITS-1:0]   z_out;
  logic               seg_done, busy;
  logic [1:0]         dbg_state;

  lineto_queue #(.BITS(BITS), .ZBITS(ZBITS), .DEPTH(DEPTH), .DIVBITS(DIVBITS)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .x_in(x_in), .y_in(y_in), .z_in(z_in), .step_div(step_div),
    .x_out(x_out), .y_out(y_out), .z_out(z_out), .seg_done(seg_done),
    .busy(busy), .dbg_state(dbg_state)
  );

  // scoreboard state
  logic [W-1:0] exp_q[$];
  int tests_run = 0;
  int tests_failed = 0;
  int done_cnt = 0;
  int px = 0;
  int py = 0;

  task automatic check(input string name, input longint act, input longint exp);
    tests_run++;
    if (act != exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic fail_event(input string name);
    tests_run++;
    tests_failed++;
    $display("FAIL %s: event occurred, expected none", name);
  endtask

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  // driver
  task automatic push_pt(input int x, input int y, input int z, output int waited);
    int xs, ys;
    @(negedge clk);
    x_in = BITS'(x);
    y_in = BITS'(y);
    z_in = ZBITS'(z);
    in_valid = 1'b1;
    waited = 0;
    while (!in_ready && waited < 3000) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready) begin
      fail_event("push_timeout");
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    xs = iabs(x - px);
    ys = iabs(y - py);
    exp_q.push_back({BITS'(x), BITS'(y), ZBITS'(z), CW'(xs), CW'(ys), step_div});
    px = x;
    py = y;
    #1 in_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n;
    int reached;
    reached = 0;
    for (n = 0; n < budget; n++) begin
      @(negedge clk);
      #1;
      if (!busy && exp_q.size() == 0) begin
        reached = 1;
        break;
      end
    end
    check(name, reached, 1);
  endtask

  // monitor: step shape, dwell, intensity, and segment results on seg_done
  logic [BITS-1:0] prev_x, prev_y;
  int mv_x, mv_y, mv_n, last_cyc, cyc = 0;

  always @(negedge clk) begin
    logic [BITS-1:0]    ex, ey;
    logic [ZBITS-1:0]   ez;
    logic [CW-1:0]      exs, eys;
    logic [DIVBITS-1:0] ediv;
    int ddx, ddy;
    cyc++;
    if (reset) begin
      prev_x = x_out;
      prev_y = y_out;
      mv_x = 0; mv_y = 0; mv_n = 0;
    end else begin
      if (x_out != prev_x || y_out != prev_y) begin
        ddx = int'(x_out) - int'(prev_x);
        ddy = int'(y_out) - int'(prev_y);
        check("step_size_le1", (iabs(ddx) <= 1 && iabs(ddy) <= 1) ? 1 : 0, 1);
        if (ddx != 0) mv_x++;
        if (ddy != 0) mv_y++;
        if (exp_q.size() > 0) begin
          {ex, ey, ez, exs, eys, ediv} = exp_q[0];
          if (!seg_done) check("z_during_step", z_out, ez);
          if (mv_n > 0) check("dwell_clocks", cyc - last_cyc, int'(ediv) + 1);
        end else begin
          fail_event("move_without_segment");
        end
        mv_n++;
        last_cyc = cyc;
      end
      if (seg_done) begin
        if (exp_q.size() == 0) begin
          fail_event("unexpected_seg_done");
        end else begin
          {ex, ey, ez, exs, eys, ediv} = exp_q.pop_front();
          check("seg_end_x", x_out, ex);
          check("seg_end_y", y_out, ey);
          check("seg_x_steps", mv_x, exs);
          check("seg_y_steps", mv_y, eys);
        end
        done_cnt++;
        mv_x = 0; mv_y = 0; mv_n = 0;
      end
      prev_x = x_out;
      prev_y = y_out;
    end
  end

  // watchdog
  initial begin
    #600000;
    $display("FAIL watchdog: got timeout expected completion");
    tests_failed++;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $fatal(1, "watchdog");
  end

  // stimulus
  initial begin
    int w, base, idle_gaps, started, z200, still, n;
    int ws[6];

    // reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_x", x_out, 0);
    check("rst_y", y_out, 0);
    check("rst_z", z_out, 0);
    check("rst_seg_done", seg_done, 0);
    check("rst_busy", busy, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_state", dbg_state, 0);
    @(negedge clk);
    #1 reset = 1'b0;

    // (0,0) -> (10,3), z=5, step_div=0, with latency checks
    step_div = 8'd0;
    push_pt(10, 3, 5, w);
    @(posedge clk);
    @(posedge clk);
    #1;
    check("lat_load_x", x_out, 0);
    check("lat_load_z", z_out, 5);
    @(posedge clk);
    #1;
    check("lat_first_x", x_out, 1);
    check("lat_first_y", y_out, 0);
    wait_idle("idle_t1", 200);
    check("t1_z_blank", z_out, 0);
    check("t1_done_cnt", done_cnt, 1);

    // blanked return to origin, then diagonal (0,0)->(7,7) with step_div=3
    push_pt(0, 0, 0, w);
    wait_idle("idle_t2a", 200);
    step_div = 8'd3;
    push_pt(7, 7, 9, w);
    wait_idle("idle_t2b", 200);

    // dot at the current position: z=200 for step_div+1 clocks
    step_div = 8'd9;
    base = done_cnt;
    push_pt(7, 7, 200, w);
    z200 = 0;
    still = 1;
    for (n = 0; n < 30; n++) begin
      @(negedge clk);
      #1;
      if (z_out == 8'd200) z200++;
      if (x_out != 12'd7 || y_out != 12'd7) still = 0;
    end
    check("dot_z_clocks", z200, 10);
    check("dot_no_move", still, 1);
    wait_idle("idle_t4", 200);
    check("dot_seg_done_once", done_cnt - base, 1);

    // DEPTH+2 points back-to-back; only the first is popped during the burst
    step_div = 8'd1;
    base = done_cnt;
    idle_gaps = 0;
    started = 0;
    fork
      begin
        push_pt(17, 7, 1, ws[0]);
        push_pt(17, 17, 2, ws[1]);
        push_pt(7, 17, 3, ws[2]);
        push_pt(7, 7, 4, ws[3]);
        push_pt(20, 12, 5, ws[4]);
        @(negedge clk);
        #1;
        check("fill_in_ready_low", in_ready, 0);
        push_pt(10, 2, 6, ws[5]);
      end
      begin
        for (n = 0; n < 2000; n++) begin
          @(negedge clk);
          #1;
          if (done_cnt - base >= 6) break;
          if (dbg_state != 2'd0) started = 1;
          else if (started && !seg_done) idle_gaps++;
        end
      end
    join
    for (int i = 0; i < 5; i++) check("fill_back_to_back", ws[i], 0);
    check("fill_last_waited", (ws[5] > 0) ? 1 : 0, 1);
    wait_idle("idle_t3", 2000);
    check("fill_seg_count", done_cnt - base, 6);
    check("fill_idle_gaps", idle_gaps, 0);

    // full scale for BITS: origin -> (max,1) -> origin
    step_div = 8'd0;
    push_pt(0, 0, 0, w);
    push_pt((1 << BITS) - 1, 1, 3, w);
    push_pt(0, 0, 3, w);
    wait_idle("idle_t5", 20000);
    check("fs_end_x", x_out, 0);
    check("fs_end_y", y_out, 0);

    // reset mid-segment with three endpoints queued
    step_div = 8'd5;
    push_pt(100, 0, 4, w);
    push_pt(0, 100, 4, w);
    push_pt(100, 100, 4, w);
    push_pt(50, 50, 4, w);
    repeat (20) @(negedge clk);
    check("pre_rst_busy", busy, 1);
    #1 reset = 1'b1;
    exp_q.delete();
    px = 0;
    py = 0;
    @(posedge clk);
    #1;
    check("mid_rst_x", x_out, 0);
    check("mid_rst_y", y_out, 0);
    check("mid_rst_z", z_out, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_in_ready", in_ready, 1);
    check("mid_rst_seg_done", seg_done, 0);
    @(negedge clk);
    #1 reset = 1'b0;
    base = done_cnt;
    repeat (20) @(negedge clk);
    check("post_rst_no_seg_done", done_cnt - base, 0);
    check("post_rst_busy", busy, 0);

    // normal operation after reset
    step_div = 8'd2;
    push_pt(3, 4, 1, w);
    wait_idle("idle_t7", 200);
    check("final_x", x_out, 3);
    check("final_y", y_out, 4);

    check("exp_q_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
